// File: rtl/wb_dual_master_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B4 classic arbiter with round-robin ties and block-cycle hold.
// Optional stall timeout is compiled in with WB_ARB_TIMEOUT_EN.
module wb_dual_master_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   last_gnt_reg, last_gnt_next;   // 0 = instruction master, 1 = data master
    logic   req0, req1;
    logic   gnt_stb;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign gnt_stb = ((state_reg == GNT_I) & m0_stb_i) | ((state_reg == GNT_D) & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] count_reg;
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    assign timeout_hit = gnt_stb & ~s_ack_i & ~s_err_i & (count_reg == COUNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if ((state_next != state_reg) || s_ack_i || s_err_i) begin
            count_reg <= '0;
        end else if (gnt_stb) begin
            count_reg <= count_reg + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = last_gnt_reg ? GNT_I : GNT_D;
                end else if (req0) begin
                    state_next = GNT_I;
                end else if (req1) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                if (timeout_hit) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b0;
                end else if (!m0_cyc_i) begin
                    // Hand straight over to a waiting data master without an idle bubble
                    last_gnt_next = 1'b0;
                    state_next    = req1 ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (timeout_hit) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b1;
                end else if (!m1_cyc_i) begin
                    last_gnt_next = 1'b1;
                    state_next    = req0 ? GNT_I : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        case (state_reg)
            GNT_I: begin
                grant_o  = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i & ~timeout_hit;
                s_stb_o  = m0_stb_i & ~timeout_hit;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout_hit;
            end
            GNT_D: begin
                grant_o  = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i & ~timeout_hit;
                s_stb_o  = m1_stb_i & ~timeout_hit;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout_hit;
            end
            default: ;
        endcase
    end

    assign busy_o = (grant_o != 2'b00);

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: reset, single grant, ties, block hold, reset abort, stall behaviour.
module tb_wb_dual_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic            m0_we_i, m1_we_i, s_we_o;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic            m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]      grant_o;
    logic            busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One acked beat for the expected grant, then that master drops cyc for one cycle
    task automatic xfer(input logic [1:0] exp);
        check("alt_grant", 32'(grant_o), 32'(exp));
        s_ack_i = 1'b1;
        settle();
        check("alt_ack", 32'({m1_ack_o, m0_ack_o}), 32'(exp));
        tick();
        s_ack_i = 1'b0;
        if (exp == 2'b01) begin
            m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        end else begin
            m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        end
        settle();
        check("alt_drop_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        if (exp == 2'b01) begin
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        end else begin
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = 32'hA5A5_A5A5; s_ack_i = 1'b0; s_err_i = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_s_adr", s_adr_o, 32'd0);
        check("rst_m0_dat", m0_dat_o, 32'd0);
        check("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);

        // Single m0 read with a two-cycle slave
        m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        settle();
        check("rd_latency", 32'(s_cyc_o), 32'd0);
        tick();
        check("rd_grant", 32'(grant_o), 32'd1);
        check("rd_busy", 32'(busy_o), 32'd1);
        check("rd_s_adr", s_adr_o, 32'h0000_0100);
        check("rd_s_cyc", 32'(s_cyc_o), 32'd1);
        tick();
        check("rd_wait_ack", 32'(m0_ack_o), 32'd0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check("rd_m0_ack", 32'(m0_ack_o), 32'd1);
        check("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("rd_m1_dat", m1_dat_o, 32'd0);
        check("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        check("rd_drop_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        check("rd_idle", 32'(grant_o), 32'd0);
        s_ack_i = 1'b1;
        settle();
        check("idle_ack_drop", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        s_ack_i = 1'b0;

        // Tie right after reset goes to data, then alternation D,I,D,I
        do_reset();
        m0_adr_i = 32'h0000_0100; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 32'h0000_0300; m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("tie_first", 32'(grant_o), 32'd2);
        check("tie_s_adr", s_adr_o, 32'h0000_0300);
        xfer(2'b10);
        xfer(2'b01);
        xfer(2'b10);
        xfer(2'b01);
        check("alt_after", 32'(grant_o), 32'd2);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        check("alt_idle", 32'(grant_o), 32'd0);

        // m1 block write held against a persistent m0 request
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 32'h0000_0200; m1_dat_i = 32'h0000_1000; m1_we_i = 1'b1; m1_sel_i = 4'hF;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            m1_adr_i = 32'h0000_0200 + 32'(4 * b);
            m1_dat_i = 32'h0000_1000 + 32'(b);
            s_ack_i = 1'b1;
            settle();
            check("blk_grant", 32'(grant_o), 32'd2);
            check("blk_s_dat", s_dat_o, 32'h0000_1000 + 32'(b));
            check("blk_s_adr", s_adr_o, 32'h0000_0200 + 32'(4 * b));
            check("blk_we_sel", 32'({s_we_o, s_sel_o}), 32'h1F);
            check("blk_acks", 32'({m1_ack_o, m0_ack_o}), 32'd2);
            tick();
            s_ack_i = 1'b0;
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        settle();
        check("blk_m0_ack", 32'(m0_ack_o), 32'd0);
        tick();
        check("blk_handover", 32'(grant_o), 32'd1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // Reset while m1 is stalled by the slave
        m1_adr_i = 32'h0000_0500; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("abort_grant", 32'(grant_o), 32'd2);
        tick(); tick();
        rst = 1'b1;
        tick();
        s_ack_i = 1'b1;
        settle();
        check("abort_s_cyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
        check("abort_grant0", 32'(grant_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        rst = 1'b0; s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Slave never answers an m0 read
        m0_adr_i = 32'h0000_0400; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        check("stall_grant", 32'(grant_o), 32'd1);
        check("stall_s_stb", 32'(s_stb_o), 32'd1);
`ifdef WB_ARB_TIMEOUT_EN
        repeat (6) tick();
        check("to_before", 32'(m0_err_o), 32'd0);
        check("to_before_stb", 32'(s_stb_o), 32'd1);
        tick();
        check("to_err", 32'(m0_err_o), 32'd1);
        check("to_cyc_forced", 32'({s_cyc_o, s_stb_o}), 32'd0);
        check("to_m1_err", 32'(m1_err_o), 32'd0);
        tick();
        check("to_err_once", 32'(m0_err_o), 32'd0);
        check("to_idle", 32'(grant_o), 32'd0);
`else
        repeat (20) tick();
        check("stall_hold", 32'(grant_o), 32'd1);
        check("stall_cyc", 32'(s_cyc_o), 32'd1);
        check("stall_no_err", 32'(m0_err_o), 32'd0);
`endif
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();
        check("end_idle", 32'(grant_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
Two-master-to-one-slave Wishbone B4 classic arbiter directly downstream of the RV32IM CPU core macro. It merges the core's instruction bus (master 0) and data bus (master 1) onto one shared memory/peripheral Wishbone port. Each transaction is fully registered-grant arbitrated, with round-robin tie-breaking and grant hold for block cycles.

Parameters:
AW, 32, address width of all ports
DW, 32, data width of all ports; select width is DW/8
TIMEOUT_CYCLES, 255, stall cycles before forced error (used only with the optional feature); legal range 1..65535

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
m0_adr_i  in  AW  instruction master address
m0_dat_i  in  DW  instruction master write data
m0_dat_o  out  DW  read data to instruction master
m0_we_i  in  1  instruction master write enable
m0_sel_i  in  DW/8  instruction master byte select
m0_cyc_i  in  1  instruction master cycle
m0_stb_i  in  1  instruction master strobe
m0_ack_o  out  1  ack to instruction master
m0_err_o  out  1  error to instruction master
m1_adr_i, m1_dat_i, m1_dat_o, m1_we_i, m1_sel_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o  same as m0 for the data master
s_adr_o  out  AW  shared slave address
s_dat_o  out  DW  shared slave write data
s_dat_i  in  DW  shared slave read data
s_we_o  out  1  slave write enable
s_sel_o  out  DW/8  slave byte select
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1; 00 = idle
busy_o  out  1  high when grant_o != 00

Behaviour:
- States: IDLE, GNT_I, GNT_D. grant_o, busy_o, and all muxing decode from the registered state.
- Reset (rst high at the clock edge): state=IDLE and last_gnt=I. Consequences: grant_o=00, busy_o=0, all s_* outputs=0, m*_ack_o=0, m*_err_o=0, m*_dat_o=0. Reset mid-transaction abandons the transfer; the slave sees cyc/stb low in the first cycle after the reset edge.
- Request: req_k = mk_cyc_i & mk_stb_i.
- IDLE transitions:
  - Only req_0 -> GNT_I.
  - Only req_1 -> GNT_D.
  - Both -> grant the master not equal to last_gnt, so the first tie after reset goes to data.
  - Arbitration latency: one cycle from request to s_cyc_o.
- GNT_x, while mx_cyc_i=1:
  - Stay in GNT_x (block cycles held, no preemption).
  - s_* outputs combinationally follow master x's signals.
  - mx_ack_o=s_ack_i, mx_err_o=s_err_i, mx_dat_o=s_dat_i.
  - The other master sees ack=0, err=0, dat_o=0 and simply stalls.
- GNT_x when mx_cyc_i drops:
  - Set last_gnt=x.
  - If the other master is requesting, go directly to its grant with no IDLE bubble; otherwise go to IDLE.
  - s_cyc_o is low for at least the cycle in which mx_cyc_i=0, since it follows the granted master.
- In IDLE: s_cyc_o=s_stb_o=s_we_o=0, and s_adr_o, s_dat_o, s_sel_o are 0.
- s_ack_i or s_err_i arriving in IDLE is ignored and not forwarded.
- Simultaneous s_ack_i and s_err_i are both forwarded. The master treats err as dominant.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every state change and whenever s_ack_i|s_err_i=1.
  - It increments each cycle while granted with s_stb_o=1 and no ack/err.
  - When count==TIMEOUT_CYCLES-1 and still no ack/err: assert mx_err_o=1 for exactly that cycle to the granted master, and force s_cyc_o=s_stb_o=0 in that cycle.
  - Next state is IDLE, last_gnt=x, and the counter clears.
  - A real ack on the same cycle wins, with no error.
- Undefined: no counter logic; the arbiter waits indefinitely for ack/err.

Test Plan:
- Reset, then m0 requests a read at adr 0x0000_0100 and the slave acks after 2 cycles with 0xDEADBEEF -> grant_o=01 one cycle after the request, m0_dat_o=0xDEADBEEF with m0_ack_o=1, then state returns to IDLE.
- m0 and m1 assert cyc/stb in the same cycle right after reset -> m1 is granted first (grant_o=10); after m1 drops cyc, grant_o=01 on the next cycle with no idle bubble.
- Two consecutive ties -> grants alternate D, I, D, I; no master receives two consecutive grants under continuous contention.
- m1 holds cyc across a 4-beat block write (sel=4'b1111, we=1) while m0 requests throughout -> m0 is never granted and m0_ack_o stays 0 until m1 cyc drops.
- Assert rst during an m1 transfer with the slave stalled -> the next cycle shows s_cyc_o=0, grant_o=00, all acks 0; a late s_ack_i is not forwarded.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks an m0 read -> m0_err_o=1 for one cycle 8 cycles after s_stb_o rose, then grant_o=00. Without the macro, the same stimulus leaves grant_o=01 indefinitely.
